// File: rtl/full_tgt_src_pkg.sv
// full_tgt_src_pkg: shared types for the target-value streaming source.
// The optional FULL_TGT_LOOP_EN feature needs no extra types here.
package full_tgt_src_pkg;

    localparam int FLOAT_W = 32;

    // 24-bit mantissa / 8-bit exponent float, carried as raw bits.
    typedef logic [FLOAT_W-1:0] float_24_8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } tgt_state_e;

endpackage

// File: rtl/full_tgt_src_mem.sv
// full_tgt_mem: DEPTH x 32 target memory, synchronous write, registered read.
// Contents are deliberately not reset.
module full_tgt_mem
    import full_tgt_src_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  float_24_8         wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output float_24_8         rd_data
);

    float_24_8 mem_q [DEPTH];

    // Write port and one-cycle registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data <= mem_q[rd_addr];
    end

endmodule

// File: rtl/full_tgt_src.sv
// full_tgt_src: streams stored target values to the error block with a
// valid/ready handshake. The memory output register acts as the prefetch
// stage; a one-entry skid register catches it when the consumer stalls.
// Optional feature: define FULL_TGT_LOOP_EN to add a stop input and
// repeat passes until stop is seen (done pulses once per pass).
//
// state     | meaning
// ST_IDLE   | host may write memory; waits for start
// ST_PRIME  | read of address 0 issued
// ST_STREAM | elements handed to the consumer
// ST_DONE   | one-cycle done pulse, then back to idle
module full_tgt_src
    import full_tgt_src_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  float_24_8         wr_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] vec_len,
    input  logic [ADDR_W-1:0] num_vec,
    output float_24_8         expected,
    output logic              expected_fst,
    output logic              expected_vld,
    input  logic              expected_rdy,
`ifdef FULL_TGT_LOOP_EN
    input  logic              stop,
`endif
    output logic              busy,
    output logic              done
);

    tgt_state_e        state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d, ptr_nxt;
    logic              a_vld_q, a_vld_d;
    logic              s_vld_q, s_vld_d;
    float_24_8         skid_q, skid_d;
    logic [ADDR_W-1:0] vl_q, vl_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] elem_q, elem_d;
    logic [ADDR_W-1:0] beat_q, beat_d;
    logic              done_q, done_d;
    logic              out_vld, xfer, issue, end_pass, mem_we;
    float_24_8         rd_data;
`ifdef FULL_TGT_LOOP_EN
    logic              stop_q, stop_d;
`endif

    // Last address of a pass: vl*nv + vl + nv equals (vl+1)*(nv+1)-1 and
    // fits in 2*ADDR_W bits; clamp to the top of memory.
    function automatic logic [ADDR_W-1:0] sat_last(input logic [ADDR_W-1:0] vl,
                                                   input logic [ADDR_W-1:0] nv);
        logic [2*ADDR_W-1:0] p;
        p = {{ADDR_W{1'b0}}, vl} * {{ADDR_W{1'b0}}, nv}
          + {{ADDR_W{1'b0}}, vl} + {{ADDR_W{1'b0}}, nv};
        if (p > (2*ADDR_W)'(DEPTH - 1)) sat_last = ADDR_W'(DEPTH - 1);
        else                            sat_last = p[ADDR_W-1:0];
    endfunction

    assign mem_we = wr_en && (state_q == ST_IDLE);

    full_tgt_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (ptr_q[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    assign out_vld      = s_vld_q | a_vld_q;
    assign xfer         = out_vld & expected_rdy;
    assign expected_vld = out_vld;
    assign expected     = s_vld_q ? skid_q : (a_vld_q ? rd_data : '0);
    assign expected_fst = out_vld & (elem_q == '0);
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;

    // State and datapath registers; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            a_vld_q <= 1'b0;
            s_vld_q <= 1'b0;
            skid_q  <= '0;
            vl_q    <= '0;
            last_q  <= '0;
            elem_q  <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
`ifdef FULL_TGT_LOOP_EN
            stop_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_vld_q <= a_vld_d;
            s_vld_q <= s_vld_d;
            skid_q  <= skid_d;
            vl_q    <= vl_d;
            last_q  <= last_d;
            elem_q  <= elem_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
`ifdef FULL_TGT_LOOP_EN
            stop_q  <= stop_d;
`endif
        end
    end

    // Next-state: sequencing, prefetch issue, skid capture and beat counting.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        a_vld_d = a_vld_q;
        s_vld_d = s_vld_q;
        skid_d  = skid_q;
        vl_d    = vl_q;
        last_d  = last_q;
        elem_d  = elem_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        issue   = 1'b0;
`ifdef FULL_TGT_LOOP_EN
        stop_d   = stop_q;
        end_pass = stop_q | stop;
        ptr_nxt  = (ptr_q[ADDR_W-1:0] == last_q) ? '0 : ptr_q + 1'b1;
`else
        end_pass = 1'b1;
        ptr_nxt  = ptr_q + 1'b1;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vl_d    = vec_len;
                    last_d  = sat_last(vec_len, num_vec);
                    ptr_d   = '0;
                    elem_d  = '0;
                    beat_d  = '0;
                    state_d = ST_PRIME;
`ifdef FULL_TGT_LOOP_EN
                    stop_d  = 1'b0;
`endif
                end
            end
            ST_PRIME: begin
                a_vld_d = 1'b1;
                ptr_d   = ptr_nxt;
                state_d = ST_STREAM;
`ifdef FULL_TGT_LOOP_EN
                stop_d  = stop_q | stop;
`endif
            end
            ST_STREAM: begin
`ifdef FULL_TGT_LOOP_EN
                stop_d = stop_q | stop;
`endif
                // The memory output changes next cycle, so a stalled
                // prefetched element moves into the skid register.
                if (s_vld_q) begin
                    s_vld_d = !xfer;
                end else begin
                    s_vld_d = a_vld_q & !xfer;
                    if (a_vld_q & !xfer) skid_d = rd_data;
                end
                issue   = !s_vld_d && (ptr_q <= {1'b0, last_q});
                a_vld_d = issue;
                if (issue) ptr_d = ptr_nxt;
                if (xfer) begin
                    elem_d = (elem_q == vl_q) ? '0 : elem_q + 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == last_q) begin
                        elem_d = '0;
                        beat_d = '0;
                        done_d = 1'b1;
                        if (end_pass) begin
                            state_d = ST_DONE;
                            a_vld_d = 1'b0;
                            s_vld_d = 1'b0;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/full_tgt_src.md
FULL_TGT_SRC -- requirements
Module: full_tgt_src

Interface
REQ-001 SHALL have parameter DEPTH, default 64: target memory entries (power of 2).
REQ-002 SHALL have parameter ADDR_W, default 6: log2(DEPTH).
REQ-003 SHALL have port clk  in  1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port wr_en  in  1: host write strobe to target memory.
REQ-006 SHALL have port wr_addr  in  ADDR_W: host write address.
REQ-007 SHALL have port wr_data  in  float_24_8 (32): target value to store.
REQ-008 SHALL have port start  in  1: one-cycle pulse that begins streaming.
REQ-009 SHALL have port vec_len  in  ADDR_W: elements per vector, minus one.
REQ-010 SHALL have port num_vec  in  ADDR_W: vectors per pass, minus one.
REQ-011 SHALL have port expected  out  float_24_8 (32): streamed target value.
REQ-012 SHALL have port expected_fst  out  1: high on the first element of each vector.
REQ-013 SHALL have port expected_vld  out  1: expected is valid.
REQ-014 SHALL have port expected_rdy  in  1: the consumer (error block) accepts the element.
REQ-015 SHALL have port busy  out  1: high in any state other than IDLE.
REQ-016 SHALL have port done  out  1: one-cycle pulse after the last element of a pass is accepted.

Function
REQ-017 SHALL implement a DEPTH x 32 memory with synchronous write and one-cycle registered read.
REQ-018 SHALL accept wr_en only in IDLE; writes in other states SHALL be ignored.
REQ-019 SHALL use the FSM IDLE -> PRIME (on start) -> STREAM -> DONE -> IDLE.
REQ-020 SHALL issue the read of address 0 in PRIME and enter STREAM on the next cycle with expected_vld=1.
REQ-021 SHALL count a transfer only in a cycle where expected_vld && expected_rdy.
REQ-022 SHALL hold expected, expected_fst and expected_vld stable while expected_vld && !expected_rdy.
REQ-023 SHALL sustain one transfer per cycle under continuous expected_rdy, using prefetch plus a one-entry skid register.
REQ-024 SHALL read addresses linearly from 0 to (vec_len+1)*(num_vec+1)-1; the product SHALL be computed at 2*ADDR_W bits and saturated at DEPTH-1.
REQ-025 SHALL assert expected_fst when the element counter is 0; the element counter SHALL wrap from vec_len to 0 and then increment the vector counter.
REQ-026 SHALL enter DONE when the last element transfers; done SHALL be high for one cycle and the FSM SHALL then return to IDLE.
REQ-027 SHALL ignore start outside IDLE.
REQ-028 SHALL latch vec_len and num_vec at start; later changes SHALL have no effect until the next start.
REQ-029 SHALL handle vec_len=0 by asserting expected_fst on every element.

Reset
REQ-030 On reset, outputs SHALL be expected=0, expected_fst=0, expected_vld=0, busy=0, done=0, and the FSM SHALL be in IDLE.
REQ-031 Reset during STREAM SHALL abort the pass within one cycle and SHALL NOT produce a done pulse.
REQ-032 Reset SHALL NOT clear memory contents.

Configuration
REQ-033 With FULL_TGT_LOOP_EN defined, the block SHALL have an extra input stop; after the last element the address SHALL wrap to 0 and streaming SHALL continue, with done pulsing once per pass. When stop is high the block SHALL finish the current pass and then return to IDLE.
REQ-034 Without FULL_TGT_LOOP_EN, the stop port SHALL be absent and each start SHALL produce exactly one pass.

Structure
REQ-035 float_24_8 and the FSM state enum SHALL be defined in the shared types package.
REQ-036 The memory SHALL be a sub-module named full_tgt_mem, taking ports clk, wr_en, wr_addr, wr_data, rd_addr and rd_data.

Verification
REQ-037 Write 0..7 with values 0x3F800000+i, vec_len=3, num_vec=1, rdy=1 -> 8 beats over 8 consecutive cycles, fst on beats 0 and 4, done one cycle after beat 7.
REQ-038 Same setup, rdy toggling 1/0 -> same 8 values in order, outputs stable during stall cycles, no beat dropped or duplicated.
REQ-039 vec_len=0, num_vec=2 -> 3 beats, each with fst=1.
REQ-040 Reset asserted after beat 2 -> expected_vld=0 on the next cycle, no done; a new start restarts the stream at address 0.
REQ-041 wr_en to address 0 during STREAM -> beats unchanged; reading after IDLE shows the original value.
REQ-042 FULL_TGT_LOOP_EN, 4 elements, stop raised during pass 2 -> exactly 8 beats, two done pulses, then IDLE.
